// File: rtl/vga_pkg.sv
// Shared VGA timing constants, scanline geometry and arbiter encodings.
// The state and owner encodings are plain localparams so they drop into older tools unchanged.
package vga_pkg;

    localparam int H_VISIBLE    = 640;
    localparam int H_TOTAL      = 800;
    localparam int V_VISIBLE    = 480;
    localparam int V_TOTAL      = 525;
    localparam int PIX_PER_WORD = 4;
    localparam int LINE_WORDS   = H_VISIBLE / PIX_PER_WORD;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_FETCH = 1'b1;

    localparam logic OWNER_FETCH = 1'b0;
    localparam logic OWNER_CPU   = 1'b1;

endpackage

// File: rtl/vram_fetch_seq.sv
// Scanline fetch sequencer: latches the line base address on start and walks
// the word counter and the CPU slot counter while the arbiter is fetching.
module vram_fetch_seq
    import vga_pkg::*;
#(
    parameter int ADDR_WIDTH      = 16,
    parameter int LINE_WORDS      = vga_pkg::LINE_WORDS,
    parameter int FB_BASE         = 0,
    parameter int CPU_SLOT_PERIOD = 4
) (
    input  logic                  pixel_clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [9:0]            line_index,
    input  logic                  active,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [7:0]            word,
    output logic                  slot,
    output logic                  last
);

    localparam int SW = $clog2(CPU_SLOT_PERIOD);

    logic [ADDR_WIDTH-1:0] base;
    logic [7:0]            w;
    logic [SW-1:0]         s;
    logic [ADDR_WIDTH+9:0] line_offset;

    // Full-width product so truncation to the VRAM address space happens only once.
    assign line_offset = (ADDR_WIDTH+10)'(line_index) * (ADDR_WIDTH+10)'(LINE_WORDS);

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            base <= '0;
            w    <= '0;
            s    <= '0;
        end else if (start) begin
            base <= ADDR_WIDTH'(FB_BASE) + line_offset[ADDR_WIDTH-1:0];
            w    <= '0;
            s    <= '0;
        end else if (active) begin
            if (advance) begin
                w <= w + 8'd1;
            end
            s <= (s == SW'(CPU_SLOT_PERIOD-1)) ? '0 : s + SW'(1);
        end
    end

    assign fetch_addr = base + ADDR_WIDTH'(w);
    assign word       = w;
    assign slot       = active && (s == SW'(CPU_SLOT_PERIOD-1));
    assign last       = (w == 8'(LINE_WORDS-1));

endmodule

// File: rtl/vram_scan_arbiter.sv
// Single-port VRAM arbiter: CPU owns the port when idle, scanline prefetch owns it
// during a fetch except for one CPU slot every CPU_SLOT_PERIOD cycles.
module vram_scan_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 16,
    parameter int LINE_WORDS      = vga_pkg::LINE_WORDS,
    parameter int FB_BASE         = 0,
    parameter int CPU_SLOT_PERIOD = 4
) (
    input  logic                  pixel_clock,
    input  logic                  reset,
    input  logic                  line_start,
    input  logic [9:0]            line_index,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  lb_we,
    output logic [7:0]            lb_addr,
    output logic [DATA_WIDTH-1:0] lb_data,
    output logic                  fetch_busy,
    output logic                  overrun
);

    logic                  state;
    logic                  rd_pend;
    logic                  rd_owner;
    logic [7:0]            rd_word;
    logic                  overrun_q;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic [7:0]            word;
    logic                  slot;
    logic                  last;
    logic                  fetching;
    logic                  cpu_take;
    logic                  fetch_issue;
    logic                  lb_pend;
    logic                  busy_raw;

    assign fetching    = (state == ST_FETCH);
    assign cpu_take    = cpu_req && (!fetching || slot);
    assign fetch_issue = fetching && !cpu_take;

    vram_fetch_seq #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .LINE_WORDS      (LINE_WORDS),
        .FB_BASE         (FB_BASE),
        .CPU_SLOT_PERIOD (CPU_SLOT_PERIOD)
    ) u_seq (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .start       (line_start),
        .line_index  (line_index),
        .active      (fetching),
        .advance     (fetch_issue),
        .fetch_addr  (fetch_addr),
        .word        (word),
        .slot        (slot),
        .last        (last)
    );

    assign lb_pend  = rd_pend && (rd_owner == OWNER_FETCH);
    assign busy_raw = fetching || lb_pend;

    // A new line_start always wins, including over the final-word exit to idle.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            rd_pend   <= 1'b0;
            rd_owner  <= OWNER_FETCH;
            rd_word   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (line_start) begin
                state <= ST_FETCH;
            end else if (fetch_issue && last) begin
                state <= ST_IDLE;
            end
            rd_pend   <= fetch_issue || (cpu_take && !cpu_we);
            rd_owner  <= fetch_issue ? OWNER_FETCH : OWNER_CPU;
            rd_word   <= word;
            overrun_q <= line_start && busy_raw;
        end
    end

    // Outputs are forced low while reset is held so a pending return is dropped immediately.
    assign cpu_gnt    = !reset && cpu_take;
    assign ram_en     = !reset && (cpu_take || fetch_issue);
    assign ram_we     = !reset && cpu_take && cpu_we;
    assign ram_addr   = (reset || !ram_en) ? '0 : (cpu_take ? cpu_addr : fetch_addr);
    assign ram_wdata  = ram_we ? cpu_wdata : '0;
    assign lb_we      = !reset && lb_pend;
    assign lb_addr    = lb_we ? rd_word : '0;
    assign lb_data    = lb_we ? ram_rdata : '0;
    assign cpu_rvalid = !reset && rd_pend && (rd_owner == OWNER_CPU);
    assign cpu_rdata  = cpu_rvalid ? ram_rdata : '0;
    assign fetch_busy = !reset && busy_raw;
    assign overrun    = !reset && overrun_q;

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Bench for vram_scan_arbiter: VRAM model, line-buffer capture and a cycle-level
// reference model built from the arbitration rules, with directed and random phases.
module tb_vram_scan_arbiter;
    import vga_pkg::*;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LW  = 160;
    localparam int P   = 4;
    localparam int FBB = 0;

    logic          pixel_clock = 1'b0;
    logic          reset       = 1'b1;
    logic          line_start  = 1'b0;
    logic [9:0]    line_index  = '0;
    logic          cpu_req     = 1'b0;
    logic          cpu_we      = 1'b0;
    logic [AW-1:0] cpu_addr    = '0;
    logic [DW-1:0] cpu_wdata   = '0;
    logic          cpu_gnt, cpu_rvalid, ram_en, ram_we, lb_we, fetch_busy, overrun;
    logic [DW-1:0] cpu_rdata, ram_wdata, lb_data;
    logic [DW-1:0] ram_rdata   = '0;
    logic [AW-1:0] ram_addr;
    logic [7:0]    lb_addr;

    vram_scan_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW), .FB_BASE(FBB), .CPU_SLOT_PERIOD(P)
    ) dut (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .line_start  (line_start),
        .line_index  (line_index),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .lb_we       (lb_we),
        .lb_addr     (lb_addr),
        .lb_data     (lb_data),
        .fetch_busy  (fetch_busy),
        .overrun     (overrun)
    );

    always #5 pixel_clock = ~pixel_clock;

    function automatic logic [15:0] pat(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5AC3;
    endfunction

    // VRAM: unwritten words read back a fixed address pattern.
    logic [15:0] mem    [0:65535];
    bit          mem_wr [0:65535];
    always @(posedge pixel_clock) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr]    <= ram_wdata;
                mem_wr[ram_addr] <= 1'b1;
            end else begin
                ram_rdata <= mem_wr[ram_addr] ? mem[ram_addr] : pat(ram_addr);
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [15:0] shadow [0:65535];
    bit          m_fetch, m_lb_p, m_rd_p, m_ovr;
    int          m_k, m_words, m_lb_idx;
    logic [15:0] m_base, m_lb_dat, m_rd_dat;

    // Last sampled DUT values and line-buffer capture
    logic        s_gnt, s_busy, s_lbwe, s_ramen, s_rv, s_ovr;
    logic [15:0] s_ramaddr, s_rdata;
    logic [15:0] lbuf [0:255];
    int          lb_writes;

    task automatic step();
        bit eg, ei, ebusy;
        logic [15:0] faddr;
        @(negedge pixel_clock);
        eg    = !reset && cpu_req && (!m_fetch || (m_k % P == P - 1));
        ei    = !reset && m_fetch && !eg;
        ebusy = !reset && (m_fetch || m_lb_p);
        faddr = m_base + 16'(m_words);
        check("cpu_gnt", 32'(cpu_gnt), 32'(eg));
        check("ram_en", 32'(ram_en), 32'(eg || ei));
        if (eg || ei) check("ram_we", 32'(ram_we), 32'(eg && cpu_we));
        if (eg) check("ram_addr_cpu", 32'(ram_addr), 32'(cpu_addr));
        else if (ei) check("ram_addr_fetch", 32'(ram_addr), 32'(faddr));
        if (eg && cpu_we) check("ram_wdata", 32'(ram_wdata), 32'(cpu_wdata));
        check("lb_we", 32'(lb_we), 32'(!reset && m_lb_p));
        if (!reset && m_lb_p) begin
            check("lb_addr", 32'(lb_addr), 32'(m_lb_idx));
            check("lb_data", 32'(lb_data), 32'(m_lb_dat));
        end
        check("cpu_rvalid", 32'(cpu_rvalid), 32'(!reset && m_rd_p));
        if (!reset && m_rd_p) check("cpu_rdata", 32'(cpu_rdata), 32'(m_rd_dat));
        check("fetch_busy", 32'(fetch_busy), 32'(ebusy));
        check("overrun", 32'(overrun), 32'(!reset && m_ovr));

        s_gnt = cpu_gnt; s_busy = fetch_busy; s_lbwe = lb_we; s_ramen = ram_en;
        s_rv = cpu_rvalid; s_ovr = overrun; s_ramaddr = ram_addr; s_rdata = cpu_rdata;
        if (lb_we) begin
            lbuf[lb_addr] = lb_data;
            lb_writes++;
        end

        if (reset) begin
            m_fetch = 0; m_lb_p = 0; m_rd_p = 0; m_ovr = 0; m_k = 0; m_words = 0;
        end else begin
            m_ovr    = line_start && ebusy;
            m_lb_p   = ei;
            m_lb_idx = m_words;
            m_lb_dat = shadow[faddr];
            m_rd_p   = eg && !cpu_we;
            m_rd_dat = shadow[cpu_addr];
            if (eg && cpu_we) shadow[cpu_addr] = cpu_wdata;
            if (ei) begin
                m_words++;
                if (m_words == LW) m_fetch = 0;
            end
            m_k++;
            if (line_start) begin
                m_fetch = 1;
                m_base  = 16'(FBB + int'(line_index) * LW);
                m_words = 0;
                m_k     = 0;
            end
        end
        @(posedge pixel_clock);
        #1;
    endtask

    task automatic clear_lbuf();
        for (int i = 0; i < 256; i++) lbuf[i] = 'x;
        lb_writes = 0;
    endtask

    task automatic check_line(input string tag, input int line);
        int bad = 0;
        logic [15:0] b = 16'(FBB + line * LW);
        for (int i = 0; i < LW; i++) begin
            if (lbuf[i] !== shadow[b + 16'(i)]) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    task automatic run_to_idle(output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < 600 && (s_busy || busy_cycles == 0); i++) begin
            step();
            if (s_busy) busy_cycles++;
            else if (i > 0) break;
        end
    endtask

    initial begin
        int busy_cnt, gnt_cnt, first_gnt, cyc;
        for (int i = 0; i < 65536; i++) shadow[i] = pat(16'(i));
        m_fetch = 0; m_lb_p = 0; m_rd_p = 0; m_ovr = 0; m_k = 0; m_words = 0;
        m_base = '0; m_lb_dat = '0; m_rd_dat = '0; m_lb_idx = 0;
        s_busy = 0;
        clear_lbuf();
        @(posedge pixel_clock);
        #1;

        // Reset holds every output low even with a request present
        reset = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0001;
        step(); step();
        check("rst_gnt", 32'(s_gnt), 32'd0);
        check("rst_ram_en", 32'(s_ramen), 32'd0);
        check("rst_busy", 32'(s_busy), 32'd0);
        reset = 0; cpu_req = 0;
        step();

        // Idle CPU write then read-back
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h00A5; cpu_wdata = 16'hBEEF;
        step();
        check("idle_wr_gnt", 32'(s_gnt), 32'd1);
        cpu_we = 0;
        step();
        check("idle_rd_gnt", 32'(s_gnt), 32'd1);
        cpu_req = 0;
        step();
        check("idle_rd_valid", 32'(s_rv), 32'd1);
        check("idle_rd_data", 32'(s_rdata), 32'hBEEF);

        // Line 2 with no CPU traffic
        clear_lbuf();
        line_start = 1; line_index = 10'd2;
        step();
        line_start = 0;
        step();
        check("l2_first_addr", 32'(s_ramaddr), 32'd320);
        busy_cnt = 1;
        for (int i = 0; i < 400 && s_busy; i++) begin
            step();
            if (s_busy) busy_cnt++;
        end
        check("l2_busy_cycles", 32'(busy_cnt), 32'd161);
        check("l2_lb_writes", 32'(lb_writes), 32'd160);
        check_line("l2_contents", 2);

        // Line 2 with the CPU requesting continuously
        clear_lbuf();
        line_start = 1; line_index = 10'd2;
        step();
        line_start = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        busy_cnt = 0; gnt_cnt = 0; first_gnt = -1; cyc = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (!s_busy) break;
            busy_cnt++;
            if (s_gnt && cyc < 213) begin
                gnt_cnt++;
                if (first_gnt < 0) first_gnt = cyc;
            end
            cyc++;
        end
        cpu_req = 0;
        check("cpu_first_slot", 32'(first_gnt), 32'd3);
        check("cpu_slot_grants", 32'(gnt_cnt), 32'd53);
        check("cpu_fetch_busy", 32'(busy_cnt), 32'd214);
        check("cpu_lb_writes", 32'(lb_writes), 32'd160);
        check_line("cpu_contents", 2);
        step();

        // Overrun: line 5 requested while word 50 of line 3 is issued
        line_start = 1; line_index = 10'd3;
        step();
        line_start = 0;
        repeat (50) step();
        clear_lbuf();
        line_start = 1; line_index = 10'd5;
        step();
        line_start = 0;
        step();
        check("ovr_pulse", 32'(s_ovr), 32'd1);
        check("ovr_restart_addr", 32'(s_ramaddr), 32'd800);
        run_to_idle(busy_cnt);
        check("ovr_busy_cycles", 32'(busy_cnt), 32'd160);
        check_line("ovr_contents", 5);

        // Reset in the cycle after a fetch read issue
        line_start = 1; line_index = 10'd7;
        step();
        line_start = 0;
        repeat (10) step();
        reset = 1; cpu_req = 1; cpu_we = 0;
        step();
        check("midrst_lb_we", 32'(s_lbwe), 32'd0);
        check("midrst_busy", 32'(s_busy), 32'd0);
        check("midrst_gnt", 32'(s_gnt), 32'd0);
        reset = 0; cpu_req = 0;
        step();
        check("postrst_idle_en", 32'(s_ramen), 32'd0);
        check("postrst_idle_busy", 32'(s_busy), 32'd0);

        // line_start and a CPU read in the same idle cycle
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
        line_start = 1; line_index = 10'd1;
        step();
        check("ls_cpu_gnt", 32'(s_gnt), 32'd1);
        line_start = 0; cpu_req = 0;
        step();
        check("ls_first_addr", 32'(s_ramaddr), 32'd160);
        check("ls_cpu_rvalid", 32'(s_rv), 32'd1);
        run_to_idle(busy_cnt);

        // Random traffic against the model
        for (int i = 0; i < 5000; i++) begin
            if (!cpu_req || s_gnt) begin
                cpu_req   = 1'($urandom_range(0, 1));
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023));
                cpu_wdata = 16'($urandom);
            end
            line_start = ($urandom_range(0, 199) == 0);
            line_index = 10'($urandom_range(0, 1023));
            reset      = ($urandom_range(0, 1999) == 0);
            step();
        end
        reset = 0; line_start = 0; cpu_req = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
